// File: rtl/codeword_bit_packer_pkg.sv
// Shared definitions for the codeword bit packer: FSM state encoding,
// default accumulator width and the fill-counter width derived from it.
// Latency: n/a (types and constants only). Backpressure: n/a.
package codeword_bit_packer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int ACC_WIDTH_DEF = 64;
    localparam int LEN_WIDTH     = 6;

    // Counter must represent 0..acc_width inclusive.
    function automatic int fill_width(input int acc_width);
        return $clog2(acc_width + 1);
    endfunction

    localparam int FILL_WIDTH = fill_width(ACC_WIDTH_DEF);

endpackage

// File: rtl/codeword_bit_packer_align.sv
// Purpose: places a right-justified codeword into the left-aligned accumulator
//          so that its first-transmitted bit lands directly after 'pos' held bits.
// Latency: combinational. Backpressure: none.
// Ports: data/len = codeword (len already clamped), pos = bits already queued,
//        aligned = codeword shifted into accumulator position, zeros elsewhere.
module codeword_bit_packer_align
    import codeword_bit_packer_pkg::*;
#(
    parameter int ENCODE_DATALENGTH = 21,
    parameter int ACC_WIDTH         = 64,
    parameter int CNT_W             = 7
) (
    input  logic [ENCODE_DATALENGTH-1:0] data,
    input  logic [LEN_WIDTH-1:0]         len,
    input  logic [CNT_W-1:0]             pos,
    output logic [ACC_WIDTH-1:0]         aligned
);

    logic [ENCODE_DATALENGTH-1:0] mask;
    logic [CNT_W:0]               shamt;

    always_comb begin
        // (1 << len) - 1 wraps to all-ones when len == ENCODE_DATALENGTH.
        mask    = (ENCODE_DATALENGTH'(1) << len) - ENCODE_DATALENGTH'(1);
        // Ready gating guarantees pos + len <= ACC_WIDTH, so no underflow.
        shamt   = (CNT_W+1)'(ACC_WIDTH) - {1'b0, pos} - (CNT_W+1)'(len);
        aligned = ACC_WIDTH'(data & mask) << shamt;
    end

endmodule

// File: rtl/codeword_bit_packer.sv
// Purpose: packs variable-length codewords MSB-first into OUT_WIDTH words; flush
//          zero-pads and closes the final partial word, tagging it word_last_o.
// Latency: a codeword that brings the fill to >= OUT_WIDTH yields a word one edge later.
// Backpressure: word_ready_i low holds the output word; cw_ready_o drops when the
//          accumulator cannot take a maximum-length codeword or while flushing.
// Ports: clk_i/rst_i (sync, active high); cw_* codeword input handshake;
//        word_* packed output handshake; flush_i/flush_done_o segment close;
//        fill_o bits held; err_len_o sticky over-length codeword flag.
module codeword_bit_packer
    import codeword_bit_packer_pkg::*;
#(
    parameter  int ENCODE_DATALENGTH = 21,
    parameter  int OUT_WIDTH         = 32,
    parameter  int ACC_WIDTH         = ACC_WIDTH_DEF,
    localparam int CNT_W             = fill_width(ACC_WIDTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cw_valid_i,
    output logic                         cw_ready_o,
    input  logic [LEN_WIDTH-1:0]         encode_length_i,
    input  logic [ENCODE_DATALENGTH-1:0] encode_data_i,
    input  logic                         flush_i,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
    output logic [OUT_WIDTH-1:0]         word_data_o,
    output logic                         word_last_o,
    output logic [CNT_W-1:0]             fill_o,
    output logic                         flush_done_o,
    output logic                         err_len_o
);

    localparam logic [CNT_W-1:0]     OUT_C     = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0]     READY_MAX = CNT_W'(ACC_WIDTH - ENCODE_DATALENGTH);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(ENCODE_DATALENGTH);

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;   // left-aligned; bits below the fill are always zero
    logic [CNT_W-1:0]       cnt;

    logic                   out_free;
    logic                   full_load;
    logic                   part_load;
    logic                   accept;
    logic [LEN_WIDTH-1:0]   len_eff;
    logic [LEN_WIDTH-1:0]   append_len;
    logic [ACC_WIDTH-1:0]   acc_rem;
    logic [CNT_W-1:0]       cnt_rem;
    logic [ACC_WIDTH-1:0]   aligned;

    assign cw_ready_o = (state == ST_RUN) && (cnt <= READY_MAX);
    assign fill_o     = cnt;

    always_comb begin
        out_free   = !word_valid_o || word_ready_i;
        accept     = cw_valid_i && cw_ready_o;
        full_load  = (state != ST_DONE) && out_free && (cnt >= OUT_C);
        // Final partial word: only while flushing, once no full word remains.
        part_load  = (state == ST_FLUSH) && out_free && (cnt < OUT_C) && (cnt != '0);
        len_eff    = (encode_length_i > MAX_LEN) ? MAX_LEN : encode_length_i;
        append_len = accept ? len_eff : '0;
        // Removal happens first so the append lands behind the surviving bits.
        acc_rem    = full_load ? (acc << OUT_WIDTH) : acc;
        cnt_rem    = full_load ? (cnt - OUT_C) : cnt;
    end

    codeword_bit_packer_align #(
        .ENCODE_DATALENGTH (ENCODE_DATALENGTH),
        .ACC_WIDTH         (ACC_WIDTH),
        .CNT_W             (CNT_W)
    ) u_align (
        .data    (encode_data_i),
        .len     (append_len),
        .pos     (cnt_rem),
        .aligned (aligned)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_RUN;
            acc          <= '0;
            cnt          <= '0;
            word_valid_o <= 1'b0;
            word_data_o  <= '0;
            word_last_o  <= 1'b0;
            flush_done_o <= 1'b0;
            err_len_o    <= 1'b0;
        end else begin
            flush_done_o <= 1'b0;

            if (accept && (encode_length_i > MAX_LEN)) begin
                err_len_o <= 1'b1;
            end

            if (part_load) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_rem | aligned;
                cnt <= cnt_rem + CNT_W'(append_len);
            end

            if (full_load || part_load) begin
                word_valid_o <= 1'b1;
                word_data_o  <= acc[ACC_WIDTH-1 -: OUT_WIDTH];
                // A full word that empties the accumulator during a flush is the last one.
                word_last_o  <= part_load || ((state == ST_FLUSH) && (cnt_rem == '0));
            end else if (word_ready_i) begin
                word_valid_o <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (flush_i) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // cnt == 0 here means either nothing was queued or the final
                    // word already left the accumulator; nothing more to emit.
                    if (part_load || (full_load && (cnt_rem == '0)) || (cnt == '0)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!word_valid_o) begin
                        flush_done_o <= 1'b1;
                        state        <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_codeword_bit_packer.sv
`timescale 1ns/1ps
module tb_codeword_bit_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cw_valid = 1'b0;
    logic        cw_ready;
    logic [5:0]  cw_len = '0;
    logic [20:0] cw_data = '0;
    logic        flush = 1'b0;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [31:0] word_data;
    logic        word_last;
    logic [6:0]  fill;
    logic        flush_done;
    logic        err_len;

    always #5 clk = ~clk;

    codeword_bit_packer dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cw_valid_i      (cw_valid),
        .cw_ready_o      (cw_ready),
        .encode_length_i (cw_len),
        .encode_data_i   (cw_data),
        .flush_i         (flush),
        .word_valid_o    (word_valid),
        .word_ready_i    (word_ready),
        .word_data_o     (word_data),
        .word_last_o     (word_last),
        .fill_o          (fill),
        .flush_done_o    (flush_done),
        .err_len_o       (err_len)
    );

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [32:0] exp_q[$];     // {last, word}
    bit          model_q[$];   // reference bit stream
    bit          hold_vld = 1'b0;
    logic [32:0] hold_word = '0;
    bit          seen_high = 1'b0;

    typedef struct {
        logic        flush;
        logic [5:0]  len;
        logic [20:0] data;
        logic        exp_vld;
        logic [31:0] exp_word;
        logic        exp_last;
        logic [6:0]  exp_fill;   // fill expected just before a flush row
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Output monitor / scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (flush_done === 1'b1) done_cnt++;
        if (fill > 7'd43) begin
            seen_high = 1'b1;
            check("ready_low_when_full", 64'(cw_ready), 64'd0);
        end
        if (hold_vld && word_valid === 1'b1)
            check("word_hold_stable", 64'({word_last, word_data}), 64'(hold_word));
        hold_vld  = (word_valid === 1'b1) && !word_ready && !rst;
        hold_word = {word_last, word_data};
        if (word_valid === 1'b1 && word_ready && !rst) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %0h expected none", {word_last, word_data});
            end else begin
                check("word", 64'({word_last, word_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1.
    task automatic send_cw(input logic [5:0] l, input logic [20:0] d);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        cw_valid = 1'b1;
        cw_len   = l;
        cw_data  = d;
        while (!done) begin
            @(negedge clk);
            if (cw_ready) done = 1'b1;
            else if (++t > 300) begin
                n_vec++;
                n_err++;
                $display("FAIL cw_accept_timeout: got ready=0 expected ready=1");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cw_valid = 1'b0;
    endtask

    task automatic model_push(input int l, input logic [20:0] d);
        int n;
        logic [31:0] w;
        n = (l > 21) ? 21 : l;
        for (int i = n - 1; i >= 0; i--) model_q.push_back(d[i]);
        while (model_q.size() >= 32) begin
            for (int j = 0; j < 32; j++) w[31-j] = model_q.pop_front();
            exp_q.push_back({1'b0, w});
        end
    endtask

    task automatic model_flush();
        logic [31:0] w;
        int n;
        w = '0;
        n = model_q.size();
        if (n > 0) begin
            for (int j = 0; j < n; j++) w[31-j] = model_q.pop_front();
            exp_q.push_back({1'b1, w});
        end
    endtask

    task automatic send_m(input logic [5:0] l, input logic [20:0] d);
        model_push(int'(l), d);
        send_cw(l, d);
    endtask

    task automatic do_flush(input string name);
        int d0;
        int t;
        d0 = done_cnt;
        t = 0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        while (done_cnt == d0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        settle(4);
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        vec_t        tbl[16];
        logic [20:0] d;
        int          d0;

        for (int i = 0; i < 6; i++)
            tbl[i] = '{1'b0, 6'd6, 21'b101101, 1'b0, 32'h0, 1'b0, 7'd0};
        tbl[5].exp_vld  = 1'b1;
        tbl[5].exp_word = 32'hB6DB6DB6;
        tbl[6] = '{1'b1, 6'd0, 21'h0, 1'b1, 32'hD0000000, 1'b1, 7'd4};
        for (int i = 7; i < 15; i++) begin
            if (i % 2 == 1) tbl[i] = '{1'b0, 6'd8,  21'b11010100,     1'b0, 32'h0, 1'b0, 7'd0};
            else            tbl[i] = '{1'b0, 6'd12, 21'b111111101001, 1'b0, 32'h0, 1'b0, 7'd0};
        end
        tbl[10].exp_vld  = 1'b1;
        tbl[10].exp_word = 32'hD4FE9D4F;
        tbl[13].exp_vld  = 1'b1;
        tbl[13].exp_word = 32'hE9D4FE9D;
        tbl[15] = '{1'b1, 6'd0, 21'h0, 1'b1, 32'h4FE90000, 1'b1, 7'd16};

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_word_valid", 64'(word_valid), 64'd0);
        check("rst_word_data",  64'(word_data),  64'd0);
        check("rst_word_last",  64'(word_last),  64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_err_len",    64'(err_len),    64'd0);
        check("rst_fill",       64'(fill),       64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cw_ready", 64'(cw_ready), 64'd1);
        check("post_rst_fill",     64'(fill),     64'd0);
        @(posedge clk);
        #1;

        // Table-driven packing and flush
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].exp_vld) exp_q.push_back({tbl[i].exp_last, tbl[i].exp_word});
            if (tbl[i].flush) begin
                settle(3);
                check("fill_before_flush", 64'(fill), 64'(tbl[i].exp_fill));
                do_flush("tbl_flush");
                check("fill_after_flush", 64'(fill), 64'd0);
            end else begin
                send_cw(tbl[i].len, tbl[i].data);
            end
        end

        // Over-length codeword and zero-length codeword
        send_m(6'd30, 21'h1F0F0F);
        settle(3);
        check("err_len_set",   64'(err_len), 64'd1);
        check("fill_len30",    64'(fill),    64'(model_q.size()));
        send_m(6'd0, 21'h1FFFFF);
        settle(3);
        check("fill_len0",     64'(fill),    64'(model_q.size()));
        send_m(6'd11, 21'h005A3);
        send_m(6'd11, 21'h0072C);
        send_m(6'd11, 21'h001FF);
        settle(3);
        check("err_len_sticky", 64'(err_len), 64'd1);
        check("fill_after_11s", 64'(fill),    64'(model_q.size()));
        model_flush();
        do_flush("err_flush");
        check("err_len_after_flush", 64'(err_len), 64'd1);

        // Backpressure while streaming maximum-length codewords
        word_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    d = 21'($urandom);
                    send_m(6'd21, d);
                end
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                word_ready = 1'b1;
            end
        join
        settle(10);
        check("bp_saw_high_fill", 64'(seen_high),     64'd1);
        check("bp_fill_drained",  64'(fill),          64'd0);
        check("bp_all_words_out", 64'(exp_q.size()),  64'd0);

        // Flush with an empty accumulator
        do_flush("empty_flush");
        check("empty_flush_no_word", 64'(word_valid), 64'd0);

        // Reset two cycles into a stalled flush
        word_ready = 1'b0;
        send_cw(6'd21, 21'h12345);
        send_cw(6'd21, 21'h0ABCD);
        d0 = done_cnt;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_cw_ready_low", 64'(cw_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_flush_word_valid", 64'(word_valid), 64'd0);
        check("rst_flush_fill",       64'(fill),       64'd0);
        check("rst_flush_err_clear",  64'(err_len),    64'd0);
        word_ready = 1'b1;
        settle(20);
        check("rst_flush_no_done",  64'(done_cnt - d0), 64'd0);
        check("rst_flush_no_word",  64'(word_valid),    64'd0);
        check("final_queue_empty",  64'(exp_q.size()),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/codeword_bit_packer.md
Name: codeword_bit_packer

Overview:
- Downstream stage of the low-entropy codebook lookup.
- Consumes the variable-length codewords the lookup emits (length plus right-justified data) and packs them MSB-first into fixed-width output words for the bitstream writer.
- Provides valid/ready handshakes on both sides, plus a flush that zero-pads and closes the final partial word at end of segment.

Parameters:
ENCODE_DATALENGTH, 21, width of the codeword data bus; must be <= OUT_WIDTH
OUT_WIDTH, 32, width of packed output word
ACC_WIDTH, 64, internal accumulator width; must be >= OUT_WIDTH + ENCODE_DATALENGTH

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
cw_valid_i  input  1  codeword present
cw_ready_o  output  1  packer can accept a codeword this cycle
encode_length_i  input  6  codeword length in bits, 0..ENCODE_DATALENGTH
encode_data_i  input  ENCODE_DATALENGTH  codeword, right-justified; bit [len-1] is transmitted first
flush_i  input  1  single-cycle request to close the current segment
word_valid_o  output  1  packed word available
word_ready_i  input  1  consumer takes the word
word_data_o  output  OUT_WIDTH  packed word; MSB is the earliest bit
word_last_o  output  1  final word of a flush
fill_o  output  7  bits currently held in the accumulator
flush_done_o  output  1  one-cycle pulse when a flush completes
err_len_o  output  1  sticky flag: a codeword arrived with length > ENCODE_DATALENGTH

Behaviour:
- Reset (rst_i high at an edge):
  - acc=0, cnt=0, state=RUN.
  - word_valid_o=0, word_data_o=0, word_last_o=0, flush_done_o=0, err_len_o=0.
  - cw_ready_o=1 after reset deasserts.
  - A reset mid-flush or mid-backpressure discards all held bits.
- Accumulator:
  - Left-aligned bit queue; cnt in 0..ACC_WIDTH.
- Input handshake:
  - cw_ready_o = (state==RUN) && (cnt <= ACC_WIDTH-ENCODE_DATALENGTH), combinational from registered state.
  - Transfer occurs when cw_valid_i && cw_ready_o.
  - len=0: accepted, no bits appended.
  - len>ENCODE_DATALENGTH: accepted, treated as ENCODE_DATALENGTH, err_len_o set until reset.
- Output register:
  - Loads when it is empty or being consumed (word_valid_o && word_ready_i) and registered cnt >= OUT_WIDTH.
  - Load takes the top OUT_WIDTH bits of acc and subtracts OUT_WIDTH from cnt.
  - word_data_o and word_last_o stay stable while word_valid_o && !word_ready_i.
- Same-edge events:
  - Removal and append may occur on the same edge; new cnt = cnt - (load ? OUT_WIDTH : 0) + len.
  - The append position is computed after removal.
- Latency: a codeword accepted at edge k that brings cnt >= OUT_WIDTH gives word_valid_o=1 after edge k+1, provided the output register is free.
- Throughput: one codeword per cycle, one word per cycle.
- States:
  - RUN: normal packing. flush_i=1 -> FLUSH; a codeword presented in the same cycle as flush_i is still accepted first.
  - FLUSH: cw_ready_o=0; drain full words.
    - When cnt < OUT_WIDTH and the output register is free or being consumed:
      - cnt>0 -> load the remaining bits, zero-padded at LSBs, with word_last_o=1; go to DONE.
      - cnt=0 and the last drained word is still pending -> mark that word word_last_o=1 if not yet loaded, else go to DONE.
      - cnt=0 and nothing sent -> DONE.
  - DONE: wait until the output register is empty; then pulse flush_done_o for 1 cycle and go to RUN.
- flush_i outside RUN is ignored.
- fill_o = cnt, registered.

Decomposition:
- Shared package: state encoding (RUN/FLUSH/DONE), ACC_WIDTH default, and fill width derived as $clog2(ACC_WIDTH+1).
- One optional sub-module, codeword_align: combinational left-shift of the right-justified codeword into the accumulator position.
- Everything else stays in the top level.

Test Plan:
- Reset -> all outputs 0, then cw_ready_o=1 and fill_o=0.
- Six codewords len=6 data='b101101, word_ready_i=1 -> one word 0xB6DB6DB6 with word_last_o=0; fill_o=4. Then flush_i -> word 0xD0000000 with word_last_o=1; flush_done_o pulses once.
- word_ready_i=0 for 10 cycles while streaming len=21 codewords -> cw_ready_o drops once fill_o>43; word_data_o stays stable; after release every input bit appears exactly once, in order.
- Alternating len=8 'b11010100 and len=12 'b111111101001 for 8 codewords (80 bits), then flush -> words 0xD4FE9D4F, 0xE9D4FE9D, 0x4FE90000 (last).
- len=30 codeword -> err_len_o=1 and stays 1 through later traffic; a len=0 codeword changes nothing.
- flush_i with fill_o=0 -> no word, flush_done_o pulse. Then flush followed by rst_i two cycles later -> word_valid_o=0, fill_o=0, no flush_done_o pulse.
